// File: rtl/lms_convergence_monitor_if.sv
// Error-stream / status bundle between the adaptive filter, the convergence monitor and control logic.
// The master drives error samples and lock settings; the slave returns MSE and lock status.
interface lms_convergence_monitor_if #(
    parameter int WIDTH = 16
);
    logic                 en;
    logic [WIDTH-1:0]     error;
    logic [2*WIDTH-1:0]   threshold;
    logic [7:0]           hold_count;
    logic [2*WIDTH-1:0]   mse;
    logic                 mse_valid;
    logic                 converged;
    logic                 lost_lock;
    logic [1:0]           state;
    logic [WIDTH-1:0]     peak_abs;

    modport master (
        output en, error, threshold, hold_count,
        input  mse, mse_valid, converged, lost_lock, state, peak_abs
    );

    modport slave (
        input  en, error, threshold, hold_count,
        output mse, mse_valid, converged, lost_lock, state, peak_abs
    );
endinterface

// File: rtl/lms_convergence_monitor.sv
// Block mean-square error over 2^WIN_LOG2-sample windows plus a lock FSM for the adaptive filter.
// Define CONV_MON_PEAK_EN to also report the per-window peak |error| on peak_abs.
module lms_convergence_monitor #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 7,
    parameter int WIN_LOG2 = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    lms_convergence_monitor_if.slave      mon
);
    localparam int SQ_W  = 2 * WIDTH;
    localparam int ACC_W = SQ_W + WIN_LOG2;

    if (FRAC >= WIDTH) begin : g_bad_format
        $error("FRAC must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    logic [SQ_W-1:0]      r_sq;
    logic                 r_sq_vld;
    logic [ACC_W-1:0]     r_acc;
    logic [WIN_LOG2-1:0]  r_cnt;
    logic [SQ_W-1:0]      r_mse;
    logic                 r_mse_valid;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_settle;
    logic [7:0]           w_settle_nxt;
    logic                 r_lost_lock;
    logic                 w_lost_lock_nxt;
    logic                 r_converged;

    logic signed [SQ_W-1:0] w_sq;
    logic [ACC_W-1:0]       w_acc_sum;
    logic [SQ_W-1:0]        w_mse_new;
    logic                   w_win_done;
    logic                   w_below;
    logic [7:0]             w_hold;
    logic [8:0]             w_settle_inc;

    // Square of a signed value is never negative; max is 2^(2*WIDTH-2), so it fits unsigned.
    assign w_sq         = $signed(mon.error) * $signed(mon.error);
    assign w_acc_sum    = r_acc + ACC_W'(r_sq);
    assign w_mse_new    = w_acc_sum[ACC_W-1:WIN_LOG2];
    assign w_win_done   = r_sq_vld && (r_cnt == {WIN_LOG2{1'b1}});
    assign w_below      = (w_mse_new < mon.threshold);
    assign w_hold       = (mon.hold_count == 8'd0) ? 8'd1 : mon.hold_count;
    assign w_settle_inc = {1'b0, r_settle} + 9'd1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq        <= '0;
            r_sq_vld    <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mse       <= '0;
            r_mse_valid <= 1'b0;
        end else begin
            r_sq_vld    <= mon.en;
            r_mse_valid <= 1'b0;
            if (mon.en) begin
                r_sq <= $unsigned(w_sq);
            end
            if (r_sq_vld) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_win_done) begin
                    r_mse       <= w_mse_new;
                    r_mse_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_settle    <= '0;
            r_lost_lock <= 1'b0;
            r_converged <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_settle    <= w_settle_nxt;
            r_lost_lock <= w_lost_lock_nxt;
            r_converged <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Lock decisions use the MSE being registered on this edge, so status moves with mse_valid.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_settle_nxt    = r_settle;
        w_lost_lock_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mon.en) w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (w_win_done && w_below) begin
                    w_settle_nxt = 8'd1;
                    w_state_nxt  = (w_hold <= 8'd1) ? ST_LOCKED : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_win_done) begin
                    if (w_below) begin
                        w_settle_nxt = w_settle_inc[7:0];
                        if (w_settle_inc >= {1'b0, w_hold}) w_state_nxt = ST_LOCKED;
                    end else begin
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_ACQUIRE;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_win_done && !w_below) begin
                    w_settle_nxt    = '0;
                    w_state_nxt     = ST_ACQUIRE;
                    w_lost_lock_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef CONV_MON_PEAK_EN
    logic [WIDTH-1:0] r_abs;
    logic [WIDTH-1:0] r_peak_run;
    logic [WIDTH-1:0] r_peak;
    logic [WIDTH-1:0] w_abs;
    logic [WIDTH-1:0] w_peak_cand;

    // The most negative code has no positive twin, so it saturates to the largest positive value.
    always_comb begin
        w_abs = mon.error;
        if (mon.error[WIDTH-1]) begin
            if (mon.error == {1'b1, {(WIDTH-1){1'b0}}}) w_abs = {1'b0, {(WIDTH-1){1'b1}}};
            else                                       w_abs = -mon.error;
        end
    end

    assign w_peak_cand = (r_abs > r_peak_run) ? r_abs : r_peak_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_abs      <= '0;
            r_peak_run <= '0;
            r_peak     <= '0;
        end else begin
            if (mon.en) r_abs <= w_abs;
            if (r_sq_vld) begin
                if (w_win_done) begin
                    r_peak     <= w_peak_cand;
                    r_peak_run <= '0;
                end else begin
                    r_peak_run <= w_peak_cand;
                end
            end
        end
    end

    assign mon.peak_abs = r_peak;
`else
    assign mon.peak_abs = '0;
`endif

    assign mon.mse       = r_mse;
    assign mon.mse_valid = r_mse_valid;
    assign mon.converged = r_converged;
    assign mon.lost_lock = r_lost_lock;
    assign mon.state     = r_state;
endmodule

// File: tb/tb_lms_convergence_monitor.sv
// Directed bench for lms_convergence_monitor: window MSE, latency, lock FSM, reset and peak tracking.
module tb_lms_convergence_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lms_convergence_monitor_if #(.WIDTH(16)) bus ();

    lms_convergence_monitor #(.WIDTH(16), .FRAC(7), .WIN_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] e);
        @(negedge clk);
        bus.en    = 1'b1;
        bus.error = e;
    endtask

    task automatic push_n(input logic [15:0] e, input int n);
        for (int i = 0; i < n; i++) push(e);
    endtask

    // Drops en and waits a bounded number of cycles for mse_valid.
    task automatic wait_mv(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (bus.mse_valid) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (bus.mse !== 32'd0) begin failures++; $display("FAIL reset_mse: got %0d expected 0", bus.mse); end
        checks++; if (bus.mse_valid !== 1'b0) begin failures++; $display("FAIL reset_mse_valid: got %0b expected 0", bus.mse_valid); end
        checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        checks++; if ({bus.converged, bus.lost_lock} !== 2'b00) begin failures++; $display("FAIL reset_status: got %b expected 00", {bus.converged, bus.lost_lock}); end
        checks++; if (bus.peak_abs !== 16'd0) begin failures++; $display("FAIL reset_peak: got %0d expected 0", bus.peak_abs); end
    endtask

    task automatic test_window_basic();
        reset_dut();
        bus.threshold  = 32'd0;
        bus.hold_count = 8'd1;
        push_n(16'd128, 16);
        @(negedge clk);
        bus.en = 1'b0;
        checks++; if (bus.mse_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %0b expected 0", bus.mse_valid); end
        @(negedge clk);
        checks++; if (bus.mse_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_latency: got %0b expected 1", bus.mse_valid); end
        checks++; if (bus.mse !== 32'd16384) begin failures++; $display("FAIL basic_mse: got %0d expected 16384", bus.mse); end
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL basic_state: got %0d expected 1", bus.state); end
`ifdef CONV_MON_PEAK_EN
        checks++; if (bus.peak_abs !== 16'd128) begin failures++; $display("FAIL basic_peak: got %0d expected 128", bus.peak_abs); end
`else
        checks++; if (bus.peak_abs !== 16'd0) begin failures++; $display("FAIL basic_peak: got %0d expected 0", bus.peak_abs); end
`endif
        @(negedge clk);
        checks++; if (bus.mse_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse: got %0b expected 0", bus.mse_valid); end
    endtask

    task automatic test_strict_threshold();
        bit found;
        bus.threshold  = 32'd16384;
        bus.hold_count = 8'd1;
        push_n(16'd128, 16);
        wait_mv(found);
        checks++; if (!found) begin failures++; $display("FAIL strict_timeout: got no mse_valid expected pulse"); end
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL strict_state: got %0d expected 1", bus.state); end
    endtask

    task automatic test_lock_hold();
        bit found;
        logic [1:0] exp_state [3] = '{2'd2, 2'd2, 2'd3};
        reset_dut();
        bus.threshold  = 32'd16385;
        bus.hold_count = 8'd3;
        for (int w = 0; w < 3; w++) begin
            push_n(16'd128, 16);
            wait_mv(found);
            checks++; if (!found) begin failures++; $display("FAIL lock_timeout: window %0d got no mse_valid", w); end
            checks++; if (bus.state !== exp_state[w]) begin failures++; $display("FAIL lock_state: window %0d got %0d expected %0d", w, bus.state, exp_state[w]); end
            checks++; if (bus.converged !== (w == 2)) begin failures++; $display("FAIL lock_converged: window %0d got %0b expected %0b", w, bus.converged, (w == 2)); end
        end
    endtask

    task automatic test_max_negative();
        bit found;
        reset_dut();
        bus.threshold = 32'd0;
        push_n(16'h8000, 16);
        wait_mv(found);
        checks++; if (!found) begin failures++; $display("FAIL maxneg_timeout: got no mse_valid expected pulse"); end
        checks++; if (bus.mse !== 32'd1073741824) begin failures++; $display("FAIL maxneg_mse: got %0d expected 1073741824", bus.mse); end
`ifdef CONV_MON_PEAK_EN
        checks++; if (bus.peak_abs !== 16'd32767) begin failures++; $display("FAIL maxneg_peak: got %0d expected 32767", bus.peak_abs); end
`endif
    endtask

    task automatic test_en_toggle();
        int pulses = 0;
        logic [31:0] seen_mse = '0;
        reset_dut();
        bus.threshold = 32'd0;
        for (int i = 0; i < 16; i++) begin
            push(16'd64);
            if (bus.mse_valid) begin pulses++; seen_mse = bus.mse; end
            @(negedge clk);
            bus.en = 1'b0;
            if (bus.mse_valid) begin pulses++; seen_mse = bus.mse; end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mse_valid) begin pulses++; seen_mse = bus.mse; end
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL toggle_pulses: got %0d expected 1", pulses); end
        checks++; if (seen_mse !== 32'd4096) begin failures++; $display("FAIL toggle_mse: got %0d expected 4096", seen_mse); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic [31:0] seen [2] = '{32'd0, 32'd0};
        reset_dut();
        bus.threshold = 32'd0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (bus.mse_valid) begin
                if (pulses < 2) seen[pulses] = bus.mse;
                pulses++;
            end
            bus.en    = (i < 32);
            bus.error = (i < 16) ? 16'd128 : 16'hFFC0;
        end
        checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (seen[0] !== 32'd16384) begin failures++; $display("FAIL b2b_mse0: got %0d expected 16384", seen[0]); end
        checks++; if (seen[1] !== 32'd4096) begin failures++; $display("FAIL b2b_mse1: got %0d expected 4096", seen[1]); end
    endtask

    task automatic test_lost_lock();
        bit found;
        reset_dut();
        bus.threshold  = 32'd16385;
        bus.hold_count = 8'd0;
        push_n(16'd128, 16);
        wait_mv(found);
        checks++; if (bus.state !== 2'd3 || bus.converged !== 1'b1) begin failures++; $display("FAIL lost_pre_lock: got state %0d conv %0b expected 3 1", bus.state, bus.converged); end
        push_n(16'd256, 16);
        wait_mv(found);
        checks++; if (!found) begin failures++; $display("FAIL lost_timeout: got no mse_valid expected pulse"); end
        checks++; if (bus.mse !== 32'd65536) begin failures++; $display("FAIL lost_mse: got %0d expected 65536", bus.mse); end
        checks++; if (bus.lost_lock !== 1'b1) begin failures++; $display("FAIL lost_pulse: got %0b expected 1", bus.lost_lock); end
        checks++; if (bus.state !== 2'd1 || bus.converged !== 1'b0) begin failures++; $display("FAIL lost_state: got state %0d conv %0b expected 1 0", bus.state, bus.converged); end
        @(negedge clk);
        checks++; if (bus.lost_lock !== 1'b0) begin failures++; $display("FAIL lost_pulse_width: got %0b expected 0", bus.lost_lock); end
    endtask

    task automatic test_reset_mid_window();
        bit found;
        bus.threshold = 32'd0;
        push_n(16'd256, 7);
        @(negedge clk);
        bus.en    = 1'b1;
        bus.error = 16'd256;
        rst       = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        checks++; if (bus.mse !== 32'd0 || bus.mse_valid !== 1'b0) begin failures++; $display("FAIL midrst_mse: got %0d valid %0b expected 0 0", bus.mse, bus.mse_valid); end
        checks++; if (bus.state !== 2'd0 || bus.converged !== 1'b0 || bus.lost_lock !== 1'b0) begin failures++; $display("FAIL midrst_state: got state %0d expected 0", bus.state); end
        push_n(16'd128, 16);
        wait_mv(found);
        checks++; if (!found) begin failures++; $display("FAIL midrst_timeout: got no mse_valid expected pulse"); end
        checks++; if (bus.mse !== 32'd16384) begin failures++; $display("FAIL midrst_mse_after: got %0d expected 16384", bus.mse); end
    endtask

    initial begin
        bus.en         = 1'b0;
        bus.error      = '0;
        bus.threshold  = '0;
        bus.hold_count = 8'd1;
        test_reset();
        test_window_basic();
        test_strict_threshold();
        test_lock_hold();
        test_max_negative();
        test_en_toggle();
        test_back_to_back();
        test_lost_lock();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lms_convergence_monitor.md
Name: lms_convergence_monitor

Overview:
- Downstream stage of the adaptive filter. Consumes the filter's signed error stream, one sample per `en` strobe.
- Computes block mean-square error (MSE) over fixed windows and runs a lock state machine.
- Reports converged / lost-lock status to control logic and to the bench monitors.
- Error input uses the same WIDTH/FRAC fixed-point format as the filter.

Parameters:
- WIDTH, 16, sample width of `error` (signed, FRAC fractional bits)
- FRAC, 7, fractional bits of `error`; `mse`/`threshold` carry 2*FRAC fractional bits
- WIN_LOG2, 4, log2 of window length (window = 2^WIN_LOG2 samples)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- en  in  1  error sample valid strobe
- error  in  WIDTH  signed filter error sample
- threshold  in  2*WIDTH  unsigned MSE lock threshold, Q.2FRAC
- hold_count  in  8  consecutive sub-threshold windows required for lock (0 treated as 1)
- mse  out  2*WIDTH  unsigned last completed window MSE, Q.2FRAC
- mse_valid  out  1  one-cycle pulse when `mse` updates
- converged  out  1  high while in LOCKED
- lost_lock  out  1  one-cycle pulse on LOCKED -> ACQUIRE
- state  out  2  IDLE=0, ACQUIRE=1, SETTLE=2, LOCKED=3
- peak_abs  out  WIDTH  window peak |error| (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state = IDLE; accumulator, sample counter and settle counter cleared. `rst` has priority over `en` in the same cycle.
- Stage 1, on `en`:
  - `sq_reg` <= error*error as full 2*WIDTH unsigned (max 2^(2*WIDTH-2), no overflow).
  - `sq_vld` <= 1; otherwise `sq_vld` <= 0.
- Stage 2, on `sq_vld`:
  - acc (2*WIDTH+WIN_LOG2 bits) += `sq_reg`; sample counter increments modulo 2^WIN_LOG2.
  - On the sample that wraps the counter: `mse` <= (acc + sq_reg) >> WIN_LOG2 (truncate); `mse_valid` pulses; acc <= 0.
- Latency: `mse_valid` is asserted 2 cycles after the `en` cycle of the last window sample. Cycles with `en` = 0 do not advance anything. Windows are non-overlapping.
- FSM, evaluated on the cycle `mse_valid` is high, using the new `mse`:
  - IDLE -> ACQUIRE on the first `en`.
  - ACQUIRE: if mse < threshold (strict), go to SETTLE with settle_cnt = 1, or go directly to LOCKED if hold_count <= 1. Otherwise stay.
  - SETTLE: if mse < threshold, increment settle_cnt and go to LOCKED when settle_cnt reaches hold_count. If mse >= threshold, go to ACQUIRE and clear settle_cnt.
  - LOCKED: if mse >= threshold, go to ACQUIRE, pulse `lost_lock` in the same cycle as the transition, and clear settle_cnt.
- `converged` = (state == LOCKED), registered with the state.
- `threshold` and `hold_count` are sampled only at window completion; changes mid-window are legal.
- `rst` mid-window discards the partial window. The next window counts 2^WIN_LOG2 fresh samples.

Optional Feature:
- Macro: CONV_MON_PEAK_EN.
- Defined:
  - Track max |error| per window; |(-2^(WIDTH-1))| saturates to 2^(WIDTH-1)-1.
  - `peak_abs` updates together with `mse` (same `mse_valid` pulse); tracker resets to 0 at window start.
- Undefined: `peak_abs` is tied to 0 and no tracking logic is present.

Test Plan:
- error = 128 (1.0) constant for 16 `en` cycles -> `mse` = 16384 (1.0 Q.14); `mse_valid` pulses exactly 2 cycles after the 16th `en`; state goes IDLE -> ACQUIRE.
- threshold = 16385, hold_count = 3, error = 128 for 48 samples -> SETTLE after window 1, still SETTLE after window 2, `converged` = 1 after window 3.
- error = -32768 for 16 samples -> `mse` = 1073741824, no wrap. With CONV_MON_PEAK_EN, `peak_abs` = 32767.
- `en` toggled 1/0 every cycle for 16 samples of error = 64 -> single `mse_valid`, `mse` = 4096; idle cycles ignored.
- LOCKED, then a window of error = 256 with threshold = 16385 -> `mse` = 65536, `lost_lock` pulses for 1 cycle, state = ACQUIRE, `converged` = 0.
- `rst` asserted on the 8th sample of a window with `en` = 1 -> all outputs 0, state = IDLE. The following 16 samples of error = 128 yield `mse` = 16384.
